// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage RV32 pipeline: load-use bubbles, EX redirects,
// mul/div occupancy and data-memory wait states. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_control_unit #(
    parameter int unsigned MD_MAX_CYCLES = 64,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_addr_ID,
    input  logic [4:0]       rs2_addr_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       rd_addr_EX,
    input  logic             branch_taken_EX,
    input  logic             md_start_EX,
    input  logic             md_done,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             flush_ID,
    output logic             flush_EX,
    output logic             bubble_MEM,
    output logic             bubble_WB,
    output logic             md_timeout,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] loaduse_count,
`endif
    output logic [1:0]       hz_state
);

    localparam int unsigned MD_CNT_W = $clog2(MD_MAX_CYCLES + 1);
    localparam logic [MD_CNT_W-1:0] MD_MAX_V = MD_CNT_W'(MD_MAX_CYCLES);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMdBusy  = 2'd1,
        StMemWait = 2'd2,
        StIllegal = 2'd3
    } hz_state_e;

    hz_state_e           r_state, w_state_d;
    logic                r_md_ret, w_md_ret_d;
    logic                r_md_done_q, w_md_done_d;
    logic                r_md_timeout, w_md_timeout_d;
    logic [MD_CNT_W-1:0] r_md_cnt, w_md_cnt_d;

    logic w_mem_wait;
    logic w_load_use;
    logic w_md_pending;
    logic w_md_finish;
    logic w_mem_hold;
    logic w_md_hold;
    logic w_fwd_ok;
    logic w_redirect;
    logic w_lu_fire;

    assign w_mem_wait = dmem_req_MEM && !dmem_ready;
    assign w_load_use = MemRead_EX && (rd_addr_EX != 5'd0) &&
                        ((rs1_used_ID && (rs1_addr_ID == rd_addr_EX)) ||
                         (rs2_used_ID && (rs2_addr_ID == rd_addr_EX)));

    // The mul/div unit is occupied in MD_BUSY and in a MEM_WAIT entered from MD_BUSY.
    assign w_md_pending = (r_state == StMdBusy) || ((r_state == StMemWait) && r_md_ret);
    assign w_md_finish  = r_md_done_q || md_done;

    always_comb begin
        w_state_d   = r_state;
        w_md_ret_d  = r_md_ret;
        w_md_done_d = r_md_done_q;
        w_md_cnt_d  = r_md_cnt;
        w_mem_hold  = 1'b0;
        w_md_hold   = 1'b0;
        w_fwd_ok    = 1'b0;

        case (r_state)
            StRun: begin
                if (w_mem_wait) begin
                    w_mem_hold  = 1'b1;
                    w_state_d   = StMemWait;
                    w_md_ret_d  = 1'b0;
                    w_md_done_d = 1'b0;
                end else if (md_start_EX) begin
                    w_md_hold   = 1'b1;
                    w_state_d   = StMdBusy;
                    w_md_cnt_d  = MD_CNT_W'(1);
                    w_md_done_d = 1'b0;
                end else begin
                    w_fwd_ok = 1'b1;
                end
            end
            StMdBusy: begin
                if (w_mem_wait) begin
                    w_mem_hold  = 1'b1;
                    w_state_d   = StMemWait;
                    w_md_ret_d  = 1'b1;
                    w_md_done_d = md_done;
                end else if (!md_done) begin
                    w_md_hold = 1'b1;
                end else begin
                    w_state_d = StRun;
                    w_fwd_ok  = 1'b1;
                end
            end
            StMemWait: begin
                if (!dmem_ready) begin
                    w_mem_hold  = 1'b1;
                    w_md_done_d = r_md_done_q || (r_md_ret && md_done);
                end else if (r_md_ret && !w_md_finish) begin
                    // Memory released but the mul/div still holds EX.
                    w_md_hold   = 1'b1;
                    w_state_d   = StMdBusy;
                    w_md_ret_d  = 1'b0;
                    w_md_done_d = 1'b0;
                end else begin
                    w_state_d   = StRun;
                    w_md_ret_d  = 1'b0;
                    w_md_done_d = 1'b0;
                    w_fwd_ok    = 1'b1;
                end
            end
            default: begin
                w_state_d   = StRun;
                w_md_ret_d  = 1'b0;
                w_md_done_d = 1'b0;
            end
        endcase

        if (w_md_pending && !w_md_finish && (r_md_cnt != MD_MAX_V)) begin
            w_md_cnt_d = r_md_cnt + MD_CNT_W'(1);
        end
        w_md_timeout_d = r_md_timeout || (w_md_cnt_d >= MD_MAX_V);
    end

    always_comb begin
        w_redirect = w_fwd_ok && branch_taken_EX;
        w_lu_fire  = w_fwd_ok && !branch_taken_EX && w_load_use;

        stall_IF   = w_mem_hold || w_md_hold || w_lu_fire;
        stall_ID   = w_mem_hold || w_md_hold || w_lu_fire;
        stall_EX   = w_mem_hold || w_md_hold;
        stall_MEM  = w_mem_hold;
        bubble_WB  = w_mem_hold;
        bubble_MEM = w_md_hold;
        flush_ID   = w_redirect;
        flush_EX   = w_redirect || w_lu_fire;

        if (rst) begin
            stall_IF   = 1'b0;
            stall_ID   = 1'b0;
            stall_EX   = 1'b0;
            stall_MEM  = 1'b0;
            bubble_WB  = 1'b0;
            bubble_MEM = 1'b0;
            flush_ID   = 1'b0;
            flush_EX   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StRun;
            r_md_ret     <= 1'b0;
            r_md_done_q  <= 1'b0;
            r_md_cnt     <= '0;
            r_md_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_md_ret     <= w_md_ret_d;
            r_md_done_q  <= w_md_done_d;
            r_md_cnt     <= w_md_cnt_d;
            r_md_timeout <= w_md_timeout_d;
        end
    end

    assign md_timeout = r_md_timeout;
    assign hz_state   = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles, r_flush_count, r_loaduse_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles  <= '0;
            r_flush_count   <= '0;
            r_loaduse_count <= '0;
        end else begin
            r_stall_cycles  <= r_stall_cycles + CNT_W'(stall_IF);
            r_flush_count   <= r_flush_count + CNT_W'(flush_ID);
            r_loaduse_count <= r_loaduse_count + CNT_W'(w_lu_fire);
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign flush_count   = r_flush_count;
    assign loaduse_count = r_loaduse_count;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed scenarios then random traffic checked
// against a behavioural model of pipeline occupancy.
module tb_hazard_control_unit;

    localparam int unsigned MAX   = 6;
    localparam int unsigned CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] rs1_addr_ID = '0, rs2_addr_ID = '0, rd_addr_EX = '0;
    logic rs1_used_ID = 0, rs2_used_ID = 0, MemRead_EX = 0, branch_taken_EX = 0;
    logic md_start_EX = 0, md_done = 0, dmem_req_MEM = 0, dmem_ready = 0;
    logic stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX;
    logic bubble_MEM, bubble_WB, md_timeout;
    logic [1:0] hz_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_count, loaduse_count;
    logic [CNT_W-1:0] m_stall_cnt = '0, m_flush_cnt = '0, m_lu_cnt = '0;
`endif

    always #5 clk = ~clk;

    hazard_control_unit #(.MD_MAX_CYCLES(MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .MemRead_EX(MemRead_EX), .rd_addr_EX(rd_addr_EX),
        .branch_taken_EX(branch_taken_EX), .md_start_EX(md_start_EX), .md_done(md_done),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
        .flush_ID(flush_ID), .flush_EX(flush_EX),
        .bubble_MEM(bubble_MEM), .bubble_WB(bubble_WB), .md_timeout(md_timeout),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
        .loaduse_count(loaduse_count),
`endif
        .hz_state(hz_state)
    );

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       mds;
        logic       mdd;
        logic       dreq;
        logic       drdy;
    } stim_t;

    typedef struct {
        logic [10:0] v;
        int          id;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc_id = 0;

    // Model: is memory pending, is the mul/div occupied, how long has it run, did it finish.
    bit m_mem_wait = 0, m_md_busy = 0, m_done_seen = 0, m_timeout = 0;
    int m_md_cycles = 0;

    task automatic model_cycle();
        exp_t e;
        logic [7:0] o;
        logic [1:0] hz;
        bit lu, mem_hold, md_occ, start;
        if (rst) begin
            m_mem_wait = 0; m_md_busy = 0; m_done_seen = 0; m_timeout = 0; m_md_cycles = 0;
`ifdef HAZARD_PERF_CNT_EN
            m_stall_cnt = '0; m_flush_cnt = '0; m_lu_cnt = '0;
`endif
            e.v = '0;
        end else begin
            hz = m_mem_wait ? 2'd2 : (m_md_busy ? 2'd1 : 2'd0);
            lu = MemRead_EX && rd_addr_EX != 0 &&
                 ((rs1_used_ID && rs1_addr_ID == rd_addr_EX) ||
                  (rs2_used_ID && rs2_addr_ID == rd_addr_EX));
            mem_hold = m_mem_wait ? !dmem_ready : (dmem_req_MEM && !dmem_ready);
            md_occ = m_md_busy && !m_done_seen && !md_done;
            start = !m_mem_wait && !m_md_busy && md_start_EX;
            // o = {sIF, sID, sEX, sMEM, fID, fEX, bMEM, bWB}
            if (mem_hold) o = 8'b1111_0001;
            else if (md_occ || start) o = 8'b1110_0010;
            else if (branch_taken_EX) o = 8'b0000_1100;
            else if (lu) o = 8'b1100_0100;
            else o = 8'b0;
            e.v = {o, m_timeout, hz};
`ifdef HAZARD_PERF_CNT_EN
            m_stall_cnt += CNT_W'(o[7]);
            m_flush_cnt += CNT_W'(o[3]);
            m_lu_cnt += CNT_W'(!mem_hold && !(md_occ || start) && !branch_taken_EX && lu);
`endif
            if (mem_hold) begin
                m_mem_wait = 1;
                if (m_md_busy && !m_done_seen) begin
                    if (md_done) m_done_seen = 1;
                    else m_md_cycles++;
                end
            end else begin
                m_mem_wait = 0;
                if (start) begin
                    m_md_busy = 1; m_md_cycles = 1; m_done_seen = 0;
                end else if (m_md_busy) begin
                    if (m_done_seen || md_done) begin
                        m_md_busy = 0; m_done_seen = 0;
                    end else begin
                        m_md_cycles++;
                    end
                end
            end
            if (m_md_cycles > int'(MAX)) m_md_cycles = MAX;
            if (m_md_cycles >= int'(MAX)) m_timeout = 1;
        end
        e.id = cyc_id;
        cyc_id++;
        q.push_back(e);
    endtask

    task automatic step(input logic r, input stim_t s);
        @(posedge clk);
        #1;
        rst = r;
        rs1_addr_ID = s.rs1; rs2_addr_ID = s.rs2; rs1_used_ID = s.u1; rs2_used_ID = s.u2;
        MemRead_EX = s.mr; rd_addr_EX = s.rd; branch_taken_EX = s.br;
        md_start_EX = s.mds; md_done = s.mdd; dmem_req_MEM = s.dreq; dmem_ready = s.drdy;
        model_cycle();
    endtask

    initial begin : monitor
        exp_t e;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX,
                       bubble_MEM, bubble_WB, md_timeout, hz_state};
                total++;
                if (act !== e.v) begin
                    bad++;
                    $display("FAIL cyc%0d outputs got=%b want=%b", e.id, act, e.v);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s, lu_s;
        step(1, '0);
        step(1, '0);
        step(0, '0);

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        lu_s = '0; lu_s.mr = 1; lu_s.rd = 5'd5; lu_s.rs1 = 5'd5; lu_s.rs2 = 5'd1; lu_s.u1 = 1;
        step(0, lu_s);
        step(0, '0);
        s = lu_s; s.rd = 5'd0; s.rs1 = 5'd0;
        step(0, s);
        s = lu_s; s.br = 1;
        step(0, s);
        step(0, '0);

        // Divide: done on the 5th busy cycle.
        s = '0; s.mds = 1;
        step(0, s);
        s = '0;
        repeat (4) step(0, s);
        s.mdd = 1;
        step(0, s);
        step(0, '0);
        step(0, lu_s);

        // Memory wait with a pending branch.
        s = '0; s.dreq = 1; s.br = 1;
        repeat (3) step(0, s);
        s.drdy = 1;
        step(0, s);
        step(0, '0);

        // Memory wait inside a divide, done arriving while memory waits.
        s = '0; s.mds = 1;
        step(0, s);
        s = '0; s.dreq = 1;
        step(0, s);
        s.mdd = 1;
        step(0, s);
        s.mdd = 0; s.drdy = 1;
        step(0, s);
        step(0, '0);

        // Reset in the middle of a divide, then a lone md_done.
        s = '0; s.mds = 1;
        step(0, s);
        step(0, '0);
        step(1, '0);
        s = '0; s.mdd = 1;
        step(0, s);

        // Timeout: divide never completes.
        s = '0; s.mds = 1;
        step(0, s);
        repeat (MAX + 2) step(0, '0);
        s = '0; s.mdd = 1;
        step(0, s);
        step(0, lu_s);

        for (int i = 0; i < 3000; i++) begin
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.rd = 5'($urandom_range(0, 3));
            s.u1 = 1'($urandom_range(0, 1));
            s.u2 = 1'($urandom_range(0, 1));
            s.mr = ($urandom_range(0, 2) == 0);
            s.br = ($urandom_range(0, 3) == 0);
            s.mds = ($urandom_range(0, 5) == 0);
            s.mdd = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
            s.dreq = ($urandom_range(0, 2) == 0);
            s.drdy = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 79) == 0), s);
        end

        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (stall_cycles !== m_stall_cnt) begin
            bad++;
            $display("FAIL stall_cycles got=%0d want=%0d", stall_cycles, m_stall_cnt);
        end
        total++;
        if (flush_count !== m_flush_cnt) begin
            bad++;
            $display("FAIL flush_count got=%0d want=%0d", flush_count, m_flush_cnt);
        end
        total++;
        if (loaduse_count !== m_lu_cnt) begin
            bad++;
            $display("FAIL loaduse_count got=%0d want=%0d", loaduse_count, m_lu_cnt);
        end
`endif
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
